qnigma_alu_seq: RTL and testbench

Initiator side of the ALU core's cal/don interface.
- Accepts arithmetic commands (mul/add/sub) that name source and destination registers in a local operand register file.
- Issues exactly one ALU request per command, waits for completion, and writes the result back.
- Host loads and reads operands through an L-bit word port.
- Sits between the protocol-level math sequencer and the ALU core.

---
 rtl/qnigma_alu_seq.sv | 196 +++++++++++++++++++
 tb/tb_qnigma_alu_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qnigma_alu_seq.sv
// qnigma_alu_seq: command sequencer driving the ALU core cal/don interface.
// Holds a local operand register file with an L-bit host word port.
module qnigma_alu_seq #(
  parameter  int N   = 16,
  parameter  int K   = 16,
  parameter  int WA  = N * K,
  parameter  int L   = 32,
  parameter  int R   = 8,
  parameter  int TMO = 1024,
  localparam int NW  = WA / L,
  localparam int RW  = $clog2(R),
  localparam int WW  = (NW > 1) ? $clog2(NW) : 1,
  localparam int TW  = $clog2(TMO + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_val,
  output logic            cmd_rdy,
  input  logic [1:0]      cmd_op,
  input  logic [RW-1:0]   cmd_ra,
  input  logic [RW-1:0]   cmd_rb,
  input  logic [RW-1:0]   cmd_rd,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_reg,
  input  logic [WW-1:0]   wr_wrd,
  input  logic [L-1:0]    wr_dat,
  input  logic [RW-1:0]   rd_reg,
  input  logic [WW-1:0]   rd_wrd,
  output logic [L-1:0]    rd_dat,
  output logic [WA-1:0]   alu_opa,
  output logic [WA-1:0]   alu_opb,
  output logic            alu_mul,
  output logic            alu_add,
  output logic            alu_sub,
  output logic            alu_cal,
  input  logic [2*WA-1:0] alu_res,
  input  logic            alu_ovf,
  input  logic            alu_don,
  output logic            done,
  output logic            ovf,
  output logic            err
);

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB_LO,
    S_WB_HI
  } st_t;

  st_t              r_st;
  logic             r_rdy;
  logic [WA-1:0]    r_opa;
  logic [WA-1:0]    r_opb;
  logic             r_mul;
  logic             r_add;
  logic             r_sub;
  logic             r_cal;
  logic             r_done;
  logic             r_ovf;
  logic             r_err;
  logic [RW-1:0]    r_rd;
  logic [2*WA-1:0]  r_res;
  logic [TW-1:0]    r_tmr;
  logic [L-1:0]     r_rdat;
  logic [WA-1:0]    r_rf [R];

  logic             w_wb;
  logic [RW-1:0]    w_wb_reg;
  logic [WA-1:0]    w_wb_dat;

  assign cmd_rdy = r_rdy;
  assign alu_opa = r_opa;
  assign alu_opb = r_opb;
  assign alu_mul = r_mul;
  assign alu_add = r_add;
  assign alu_sub = r_sub;
  assign alu_cal = r_cal;
  assign done    = r_done;
  assign ovf     = r_ovf;
  assign err     = r_err;
  assign rd_dat  = r_rdat;

  assign w_wb     = (r_st == S_WB_LO) || (r_st == S_WB_HI);
  assign w_wb_reg = (r_st == S_WB_HI) ? r_rd + RW'(1) : r_rd;
  assign w_wb_dat = (r_st == S_WB_HI) ? r_res[2*WA-1:WA]
                                      : r_res[WA-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st   <= S_IDLE;
      r_rdy  <= 1'b1;
      r_opa  <= '0;
      r_opb  <= '0;
      r_mul  <= 1'b0;
      r_add  <= 1'b0;
      r_sub  <= 1'b0;
      r_cal  <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
      r_rd   <= '0;
      r_res  <= '0;
      r_tmr  <= '0;
    end else begin
      r_done <= 1'b0;
      r_cal  <= 1'b0;
      unique case (r_st)
        S_IDLE: begin
          if (cmd_val) begin
            if (cmd_op == OP_RSV) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_rd  <= cmd_rd;
              r_opa <= r_rf[cmd_ra];
              r_opb <= r_rf[cmd_rb];
              r_mul <= (cmd_op == OP_MUL);
              r_add <= (cmd_op == OP_ADD);
              r_sub <= (cmd_op == OP_SUB);
              r_cal <= 1'b1;
              r_rdy <= 1'b0;
              r_st  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_tmr <= TW'(1);
          r_st  <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_don) begin
            r_res <= alu_res;
            r_st  <= S_WB_LO;
            // add/sub finish in WB_LO, so their flags go out with it
            if (r_mul) begin
              r_ovf <= 1'b0;
            end else begin
              r_ovf  <= alu_ovf;
              r_done <= 1'b1;
            end
          end else if (r_tmr >= TW'(TMO - 1)) begin
            r_err  <= 1'b1;
            r_done <= 1'b1;
            r_rdy  <= 1'b1;
            r_st   <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_WB_LO: begin
          if (r_mul) begin
            r_done <= 1'b1;
            r_st   <= S_WB_HI;
          end else begin
            r_rdy <= 1'b1;
            r_st  <= S_IDLE;
          end
        end
        S_WB_HI: begin
          r_rdy <= 1'b1;
          r_st  <= S_IDLE;
        end
        default: begin
          r_rdy <= 1'b1;
          r_st  <= S_IDLE;
        end
      endcase
    end
  end

  // writeback is assigned last so it wins a same-cycle host write
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_rf[wr_reg][L*wr_wrd +: L] <= wr_dat;
    end
    if (w_wb) begin
      r_rf[w_wb_reg] <= w_wb_dat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdat <= '0;
    end else begin
      r_rdat <= r_rf[rd_reg][L*rd_wrd +: L];
    end
  end

endmodule

// File: tb/tb_qnigma_alu_seq.sv
// tb_qnigma_alu_seq: directed vectors for qnigma_alu_seq with
// a small behavioural ALU responder (N=2, K=8, L=8, TMO=16).
module tb_qnigma_alu_seq;

  localparam int N   = 2;
  localparam int K   = 8;
  localparam int WA  = 16;
  localparam int L   = 8;
  localparam int R   = 8;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_ra;
  logic [2:0]  cmd_rb;
  logic [2:0]  cmd_rd;
  logic        wr_en;
  logic [2:0]  wr_reg;
  logic [0:0]  wr_wrd;
  logic [7:0]  wr_dat;
  logic [2:0]  rd_reg;
  logic [0:0]  rd_wrd;
  logic [7:0]  rd_dat;
  logic [15:0] alu_opa;
  logic [15:0] alu_opb;
  logic        alu_mul;
  logic        alu_add;
  logic        alu_sub;
  logic        alu_cal;
  logic [31:0] alu_res = '0;
  logic        alu_ovf = 1'b0;
  logic        alu_don = 1'b0;
  logic        done;
  logic        ovf;
  logic        err;

  qnigma_alu_seq #(
    .N(N), .K(K), .WA(WA), .L(L), .R(R), .TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_wrd(wr_wrd),
    .wr_dat(wr_dat), .rd_reg(rd_reg), .rd_wrd(rd_wrd),
    .rd_dat(rd_dat), .alu_opa(alu_opa), .alu_opb(alu_opb),
    .alu_mul(alu_mul), .alu_add(alu_add), .alu_sub(alu_sub),
    .alu_cal(alu_cal), .alu_res(alu_res), .alu_ovf(alu_ovf),
    .alu_don(alu_don), .done(done), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc = 0, cal_cnt = 0, done_cnt = 0, t_cal = 0, t_done = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (alu_cal) begin
      cal_cnt = cal_cnt + 1;
      t_cal   = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      t_done   = cyc;
    end
  end

  int          alu_lat = 3;
  bit          alu_en  = 1'b1;
  bit          a_busy  = 1'b0;
  int          a_cnt   = 0;
  logic [16:0] a_sum;

  always @(negedge clk) begin
    alu_don = 1'b0;
    if (a_busy) begin
      if (a_cnt <= 1) begin
        alu_don = 1'b1;
        a_busy  = 1'b0;
      end else begin
        a_cnt = a_cnt - 1;
      end
    end
    if (alu_cal && alu_en) begin
      a_busy = 1'b1;
      a_cnt  = alu_lat;
      if (alu_mul) begin
        alu_res = {16'h0, alu_opa} * {16'h0, alu_opb};
        alu_ovf = 1'b0;
      end else if (alu_add) begin
        a_sum   = {1'b0, alu_opa} + {1'b0, alu_opb};
        alu_res = {16'h0, a_sum[15:0]};
        alu_ovf = a_sum[16];
      end else begin
        alu_res = {16'h0, alu_opa - alu_opb};
        alu_ovf = (alu_opa < alu_opb);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic hwr(input logic [2:0] r, input logic [15:0] v);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_reg = r; wr_wrd = 1'b0; wr_dat = v[7:0];
    @(posedge clk); #1;
    wr_wrd = 1'b1; wr_dat = v[15:8];
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic hrd(input logic [2:0] r, output logic [15:0] v);
    @(posedge clk); #1;
    rd_reg = r; rd_wrd = 1'b0;
    @(posedge clk); #1;
    v[7:0] = rd_dat; rd_wrd = 1'b1;
    @(posedge clk); #1;
    v[15:8] = rd_dat;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [2:0] rd);
    @(posedge clk); #1;
    for (int i = 0; i < 50 && !cmd_rdy; i++) begin
      @(posedge clk); #1;
    end
    chk("cmd_rdy_wait", {31'h0, cmd_rdy}, 32'h1);
    cmd_val = 1'b1; cmd_op = op;
    cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
    @(posedge clk); #1;
    cmd_val = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) seen = 1'b1;
    end
  endtask

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        ov;
    logic        mul;
  } vec_t;

  vec_t        tv [5];
  logic [15:0] v;
  bit          seen;
  int          d0, c0;

  initial begin
    tv[0] = '{op:2'd0, ra:3'd0, rb:3'd1, rd:3'd2, a:16'h1234,
              b:16'h0010, lo:16'h2340, hi:16'h0001, ov:1'b0, mul:1'b1};
    tv[1] = '{op:2'd1, ra:3'd4, rb:3'd5, rd:3'd4, a:16'hFFFF,
              b:16'h0001, lo:16'h0000, hi:16'h0000, ov:1'b1, mul:1'b0};
    tv[2] = '{op:2'd1, ra:3'd5, rb:3'd5, rd:3'd5, a:16'h0001,
              b:16'h0001, lo:16'h0002, hi:16'h0000, ov:1'b0, mul:1'b0};
    tv[3] = '{op:2'd2, ra:3'd0, rb:3'd1, rd:3'd6, a:16'h0005,
              b:16'h0007, lo:16'hFFFE, hi:16'h0000, ov:1'b1, mul:1'b0};
    tv[4] = '{op:2'd0, ra:3'd2, rb:3'd2, rd:3'd7, a:16'h0100,
              b:16'h0100, lo:16'h0000, hi:16'h0001, ov:1'b0, mul:1'b1};

    rst = 1'b0; cmd_val = 1'b0; cmd_op = '0;
    cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
    wr_en = 1'b0; wr_reg = '0; wr_wrd = '0; wr_dat = '0;
    rd_reg = '0; rd_wrd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",  {31'h0, cmd_rdy}, 32'h1);
    chk("rst_cal",  {31'h0, alu_cal}, 32'h0);
    chk("rst_done", {31'h0, done},    32'h0);
    chk("rst_ovf",  {31'h0, ovf},     32'h0);
    chk("rst_err",  {31'h0, err},     32'h0);
    chk("rst_rdat", {24'h0, rd_dat},  32'h0);
    chk("rst_opa",  {16'h0, alu_opa}, 32'h0);
    chk("rst_mul",  {31'h0, alu_mul}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      hwr(tv[i].ra, tv[i].a);
      hwr(tv[i].rb, tv[i].b);
      d0 = done_cnt; c0 = cal_cnt;
      issue(tv[i].op, tv[i].ra, tv[i].rb, tv[i].rd);
      wait_done(d0, seen);
      chk($sformatf("v%0d_done", i), {31'h0, seen}, 32'h1);
      chk($sformatf("v%0d_ovf", i), {31'h0, ovf}, {31'h0, tv[i].ov});
      chk($sformatf("v%0d_lat", i), t_done - t_cal,
          tv[i].mul ? alu_lat + 2 : alu_lat + 1);
      hrd(tv[i].rd, v);
      chk($sformatf("v%0d_lo", i), {16'h0, v}, {16'h0, tv[i].lo});
      if (tv[i].mul) begin
        hrd(tv[i].rd + 3'd1, v);
        chk($sformatf("v%0d_hi", i), {16'h0, v}, {16'h0, tv[i].hi});
      end
      chk($sformatf("v%0d_cal", i), cal_cnt - c0, 1);
      chk($sformatf("v%0d_dcnt", i), done_cnt - d0, 1);
    end

    // watchdog: responder silent
    alu_en = 1'b0;
    d0 = done_cnt;
    issue(2'd1, 3'd0, 3'd1, 3'd6);
    wait_done(d0, seen);
    chk("wd_done", {31'h0, seen}, 32'h1);
    chk("wd_lat", t_done - t_cal, TMO);
    chk("wd_err", {31'h0, err}, 32'h1);
    hrd(3'd6, v);
    chk("wd_r6", {16'h0, v}, 32'hFFFE);
    alu_en = 1'b1;
    d0 = done_cnt;
    issue(2'd1, 3'd5, 3'd5, 3'd5);
    wait_done(d0, seen);
    chk("wd_next_done", {31'h0, seen}, 32'h1);
    hrd(3'd5, v);
    chk("wd_next_r5", {16'h0, v}, 32'h0004);
    chk("wd_err_sticky", {31'h0, err}, 32'h1);

    // reset while waiting on a slow ALU
    hwr(3'd1, 16'h0007);
    hwr(3'd3, 16'hAAAA);
    hwr(3'd4, 16'h5555);
    alu_lat = 8;
    d0 = done_cnt;
    issue(2'd0, 3'd1, 3'd1, 3'd3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_rdy",  {31'h0, cmd_rdy}, 32'h1);
    chk("mr_cal",  {31'h0, alu_cal}, 32'h0);
    chk("mr_done", {31'h0, done},    32'h0);
    chk("mr_err",  {31'h0, err},     32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    chk("mr_no_done", done_cnt - d0, 0);
    hrd(3'd3, v);
    chk("mr_r3", {16'h0, v}, 32'hAAAA);
    hrd(3'd4, v);
    chk("mr_r4", {16'h0, v}, 32'h5555);
    alu_lat = 3;

    // reserved opcode
    d0 = done_cnt; c0 = cal_cnt;
    issue(2'd3, 3'd0, 3'd0, 3'd0);
    wait_done(d0, seen);
    chk("rsv_done", {31'h0, seen}, 32'h1);
    chk("rsv_err", {31'h0, err}, 32'h1);
    repeat (4) @(negedge clk);
    #1;
    chk("rsv_nocal", cal_cnt - c0, 0);
    chk("rsv_dcnt", done_cnt - d0, 1);
    chk("rsv_rdy", {31'h0, cmd_rdy}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
